// File: rtl/dmem_arb_pkg.sv
//==============================================================================
// dmem_arb_pkg : shared types and helpers for the data-memory arbiter
// Revision     : 1.0
//==============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int MAX_CH  = 8;
    localparam int c_idx_w = $clog2(MAX_CH);

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Isolates the least-significant set bit (two's-complement trick).
    function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] v);
        return v & (~v + MAX_CH'(1));
    endfunction

    function automatic logic [c_idx_w-1:0] onehot_idx(input logic [MAX_CH-1:0] oh);
        logic [c_idx_w-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = c_idx_w'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arb_sel.sv
//==============================================================================
// dmem_arb_sel : one-hot grant selection (starvation override, fixed or RR)
// Revision     : 1.0
//==============================================================================
`default_nettype none

module dmem_arb_sel
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PTR_W  = $clog2(NUM_CH)
)(
    input  logic [NUM_CH-1:0] valid_i,
    input  logic [PTR_W-1:0]  rr_ptr_i,
    input  arb_mode_t         mode_i,
    input  logic [NUM_CH-1:0] starve_i,
    output logic [NUM_CH-1:0] grant_o
);

    logic [NUM_CH-1:0]   w_starved;
    logic [NUM_CH-1:0]   w_rot;
    logic [NUM_CH-1:0]   w_pick;
    logic [2*NUM_CH-1:0] w_dbl;
    logic [2*NUM_CH-1:0] w_back;

    always_comb begin
        w_starved = valid_i & starve_i;
        // Round-robin: rotate so rr_ptr sits at bit 0, pick lowest, rotate back.
        w_dbl     = {valid_i, valid_i} >> rr_ptr_i;
        w_rot     = w_dbl[NUM_CH-1:0];
        w_pick    = NUM_CH'(lowest_set(MAX_CH'(w_rot)));
        w_back    = {w_pick, w_pick} << rr_ptr_i;
        if (|w_starved) begin
            grant_o = NUM_CH'(lowest_set(MAX_CH'(w_starved)));
        end else if (mode_i == ARB_RR) begin
            grant_o = w_back[2*NUM_CH-1:NUM_CH];
        end else begin
            grant_o = NUM_CH'(lowest_set(MAX_CH'(valid_i)));
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter_n.sv
//==============================================================================
// dmem_arbiter_n : N-channel arbiter onto a single-outstanding cache port.
// Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN. Revision 1.0
//==============================================================================
`default_nettype none

module dmem_arbiter_n
    import dmem_arb_pkg::*;
#(
    parameter int                NUM_CH       = 3,
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                ARB_MODE     = 0,
    parameter logic [NUM_CH-1:0] FLUSH_MASK   = {{(NUM_CH-1){1'b0}}, 1'b1},
    parameter int                STARVE_LIMIT = 16,
    localparam int               MASK_W       = DATA_W / 8
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           backend_flush,
    input  logic [NUM_CH-1:0]              req_valid,
    output logic [NUM_CH-1:0]              req_ready,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_CH-1:0][MASK_W-1:0]  req_rmask,
    input  logic [NUM_CH-1:0][MASK_W-1:0]  req_wmask,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_CH-1:0]              resp_valid,
    output logic [DATA_W-1:0]              resp_rdata,
    output logic [ADDR_W-1:0]              dmem_addr,
    output logic [MASK_W-1:0]              dmem_rmask,
    output logic [MASK_W-1:0]              dmem_wmask,
    output logic [DATA_W-1:0]              dmem_wdata,
    input  logic [DATA_W-1:0]              dmem_rdata,
    input  logic                           dmem_resp
);

    localparam int        c_ptr_w = $clog2(NUM_CH);
    localparam arb_mode_t c_mode  = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    logic               pending_q, pending_d;
    logic               flushed_q, flushed_d;
    logic [c_ptr_w-1:0] owner_q,   owner_d;
    logic [c_ptr_w-1:0] rr_ptr_q,  rr_ptr_d;

    logic               w_busy;
    logic               w_can_grant;
    logic               w_hs;
    logic [c_ptr_w-1:0] w_gnt_idx;
    logic [NUM_CH-1:0]  w_gnt;
    logic [NUM_CH-1:0]  w_starve;

    assign w_busy = pending_q & ~dmem_resp;
    // A flushed request still frees the port in its dmem_resp cycle.
    assign w_can_grant = ~rst & ~w_busy & ~(flushed_q & ~dmem_resp);

    dmem_arb_sel #(
        .NUM_CH (NUM_CH),
        .PTR_W  (c_ptr_w)
    ) u_sel (
        .valid_i  (req_valid & {NUM_CH{w_can_grant}}),
        .rr_ptr_i (rr_ptr_q),
        .mode_i   (c_mode),
        .starve_i (w_starve),
        .grant_o  (w_gnt)
    );

    assign req_ready  = w_gnt;
    assign w_hs       = |w_gnt;
    assign w_gnt_idx  = c_ptr_w'(onehot_idx(MAX_CH'(w_gnt)));

    assign dmem_addr  = req_addr[w_gnt_idx];
    assign dmem_wdata = req_wdata[w_gnt_idx];
    assign dmem_rmask = w_hs ? req_rmask[w_gnt_idx] : '0;
    assign dmem_wmask = w_hs ? req_wmask[w_gnt_idx] : '0;
    assign resp_rdata = dmem_rdata;

    always_comb begin
        resp_valid = '0;
        if (dmem_resp && pending_q && !flushed_q) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    always_comb begin
        pending_d = pending_q;
        flushed_d = flushed_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        if (w_hs) begin
            pending_d = 1'b1;
            owner_d   = w_gnt_idx;
            if (c_mode == ARB_RR) begin
                rr_ptr_d = (w_gnt_idx == c_ptr_w'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end else if (dmem_resp) begin
            pending_d = 1'b0;
        end
        if (dmem_resp) begin
            flushed_d = 1'b0;
        end else if (backend_flush && w_busy && FLUSH_MASK[owner_q]) begin
            flushed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            flushed_q <= 1'b0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pending_q <= pending_d;
            flushed_q <= flushed_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int c_cnt_w = $clog2(STARVE_LIMIT + 2);

    logic [NUM_CH-1:0][c_cnt_w-1:0] wait_q, wait_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wait_d[i]   = wait_q[i];
            w_starve[i] = (wait_q[i] >= c_cnt_w'(STARVE_LIMIT));
            if (w_gnt[i]) begin
                wait_d[i] = '0;
            end else if (req_valid[i] && (wait_q[i] < c_cnt_w'(STARVE_LIMIT))) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign w_starve = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter_n.sv
//==============================================================================
// tb_dmem_arbiter_n : fixed-priority and round-robin instances on shared stimulus
// Revision          : 1.0
//==============================================================================
`default_nettype none

module tb_dmem_arbiter_n;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int SL = 4;
`else
    localparam int SL = 16;
`endif
    localparam logic [N-1:0] FM = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   backend_flush;
    logic                   dmem_resp;
    logic [N-1:0]           req_valid;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][MW-1:0]   req_rmask;
    logic [N-1:0][MW-1:0]   req_wmask;
    logic [N-1:0][DW-1:0]   req_wdata;
    logic [DW-1:0]          dmem_rdata;

    logic [N-1:0]  o_ready [2];
    logic [N-1:0]  o_rv    [2];
    logic [DW-1:0] o_rdata [2];
    logic [DW-1:0] o_wdata [2];
    logic [AW-1:0] o_addr  [2];
    logic [MW-1:0] o_rmask [2];
    logic [MW-1:0] o_wmask [2];

    dmem_arbiter_n #(
        .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0),
        .FLUSH_MASK(FM), .STARVE_LIMIT(SL)
    ) u_fix (
        .clk(clk), .rst(rst), .backend_flush(backend_flush),
        .req_valid(req_valid), .req_ready(o_ready[0]),
        .req_addr(req_addr), .req_rmask(req_rmask), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .resp_valid(o_rv[0]), .resp_rdata(o_rdata[0]),
        .dmem_addr(o_addr[0]), .dmem_rmask(o_rmask[0]), .dmem_wmask(o_wmask[0]),
        .dmem_wdata(o_wdata[0]), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    dmem_arbiter_n #(
        .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1),
        .FLUSH_MASK(FM), .STARVE_LIMIT(SL)
    ) u_rr (
        .clk(clk), .rst(rst), .backend_flush(backend_flush),
        .req_valid(req_valid), .req_ready(o_ready[1]),
        .req_addr(req_addr), .req_rmask(req_rmask), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .resp_valid(o_rv[1]), .resp_rdata(o_rdata[1]),
        .dmem_addr(o_addr[1]), .dmem_rmask(o_rmask[1]), .dmem_wmask(o_wmask[1]),
        .dmem_wdata(o_wdata[1]), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: instance 0 = fixed priority, instance 1 = round-robin.
    bit m_pend  [2];
    bit m_fl    [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_wait  [2][N];
    int exp_g   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic string tagk(input string s, input int k);
        return $sformatf("u%0d.%s", k, s);
    endfunction

    function automatic int model_grant(input int k);
        if (rst) return -1;
        if (m_pend[k] && !dmem_resp) return -1;
        if (m_fl[k] && !dmem_resp) return -1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int c = 0; c < N; c++) begin
            if (req_valid[c] && m_wait[k][c] >= SL) return c;
        end
`endif
        for (int j = 0; j < N; j++) begin
            int c;
            c = (k == 0) ? j : (m_ptr[k] + j) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 1'b0; m_fl[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0; exp_g[k] = -1;
            for (int c = 0; c < N; c++) m_wait[k][c] = 0;
        end
    endtask

    task automatic eval();
        #4;
        for (int k = 0; k < 2; k++) begin
            int g;
            logic [N-1:0] er;
            logic [N-1:0] erv;
            g = model_grant(k);
            exp_g[k] = g;
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk(tagk("ready", k), o_ready[k], er);
            if (g >= 0) begin
                chk(tagk("rmask", k), o_rmask[k], req_rmask[g]);
                chk(tagk("wmask", k), o_wmask[k], req_wmask[g]);
                chk(tagk("addr", k),  o_addr[k],  req_addr[g]);
                chk(tagk("wdata", k), o_wdata[k], req_wdata[g]);
            end else begin
                chk(tagk("rmask_idle", k), o_rmask[k], 0);
                chk(tagk("wmask_idle", k), o_wmask[k], 0);
            end
            erv = '0;
            if (dmem_resp && m_pend[k] && !m_fl[k]) erv[m_owner[k]] = 1'b1;
            chk(tagk("resp_valid", k), o_rv[k], erv);
            chk(tagk("rdata", k), o_rdata[k], dmem_rdata);
        end
    endtask

    task automatic commit();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int g;
            g = exp_g[k];
            for (int c = 0; c < N; c++) begin
                if (g == c) m_wait[k][c] = 0;
                else if (req_valid[c] && m_wait[k][c] < SL) m_wait[k][c]++;
            end
            if (dmem_resp) m_fl[k] = 1'b0;
            else if (backend_flush && m_pend[k] && FM[m_owner[k]]) m_fl[k] = 1'b1;
            if (g >= 0) begin
                m_pend[k]  = 1'b1;
                m_owner[k] = g;
                if (k == 1) m_ptr[k] = (g + 1) % N;
            end else if (dmem_resp) begin
                m_pend[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cyc();
        eval();
        commit();
    endtask

    task automatic rand_data();
        for (int c = 0; c < N; c++) begin
            req_addr[c]  = $urandom;
            req_rmask[c] = MW'($urandom);
            req_wmask[c] = MW'($urandom);
            req_wdata[c] = $urandom;
        end
        dmem_rdata = $urandom;
    endtask

    // Asynchronous reset with live inputs: outputs must stay quiet throughout.
    task automatic do_reset();
        rst           = 1'b1;
        req_valid     = N'($urandom) | 3'b001;
        dmem_resp     = 1'b1;
        backend_flush = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk(tagk("rst_ready", k), o_ready[k], 0);
            chk(tagk("rst_rv", k),    o_rv[k],    0);
            chk(tagk("rst_rmask", k), o_rmask[k], 0);
            chk(tagk("rst_wmask", k), o_wmask[k], 0);
        end
        @(posedge clk);
        #1;
        mreset();
        rst           = 1'b0;
        req_valid     = '0;
        dmem_resp     = 1'b0;
        backend_flush = 1'b0;
    endtask

    logic [N-1:0] rr_ord [4];
    int           hit;

    initial begin
        rst = 1'b0; backend_flush = 1'b0; dmem_resp = 1'b0; req_valid = '0;
        rand_data();
        mreset();
        rr_ord = '{3'b001, 3'b010, 3'b100, 3'b001};
        #1;
        do_reset();

        // Fixed priority with all channels valid keeps choosing ch0
        rand_data();
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            dmem_resp = (i > 0);
            rand_data();
            eval();
            chk("r032_grant", o_ready[0], 3'b001);
            commit();
        end
        req_valid = '0; dmem_resp = 1'b1; cyc(); dmem_resp = 1'b0;

        // Round-robin order and exactly one response per dmem_resp
        do_reset();
        req_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            dmem_resp = (i > 0);
            rand_data();
            eval();
            chk("r033_order", o_ready[1], rr_ord[i]);
            if (i > 0) chk("r033_onehot", $countones(o_rv[1]), 1);
            commit();
        end
        req_valid = '0; dmem_resp = 1'b1; cyc(); dmem_resp = 1'b0;

        // Flushed read: squashed response, stall, regrant in dmem_resp cycle
        rand_data();
        req_valid = 3'b001; req_addr[0] = 32'h100; req_rmask[0] = 4'hF; req_wmask[0] = 4'h0;
        eval();
        chk("r034_addr",  o_addr[0],  32'h100);
        chk("r034_rmask", o_rmask[0], 4'hF);
        commit();
        req_valid = 3'b010; backend_flush = 1'b1; cyc(); backend_flush = 1'b0;
        eval();
        chk("r034_stall", o_ready[0], 0);
        commit();
        dmem_resp = 1'b1;
        eval();
        chk("r034_squash",  o_rv[0],    0);
        chk("r034_regrant", o_ready[0], 3'b010);
        commit();
        req_valid = '0; cyc(); dmem_resp = 1'b0;

        // Non-flushable owner keeps its response
        req_valid = 3'b010; req_wmask[1] = 4'hF; req_rmask[1] = 4'h0; cyc();
        req_valid = '0; backend_flush = 1'b1; cyc(); backend_flush = 1'b0;
        dmem_resp = 1'b1;
        eval();
        chk("r035_deliver", o_rv[0], 3'b010);
        commit();
        dmem_resp = 1'b0;

        // Reset while a request is outstanding abandons it
        req_valid = 3'b001; cyc();
        req_valid = '0;
        do_reset();
        req_valid = 3'b001; dmem_resp = 1'b1;
        eval();
        chk("r037_norv",  o_rv[0],    0);
        chk("r037_ready", o_ready[0], 3'b001);
        commit();
        req_valid = '0; cyc(); dmem_resp = 1'b0;

`ifdef DMEM_ARB_STARVE_GUARD_EN
        do_reset();
        req_valid = 3'b101;
        hit = -1;
        for (int i = 0; i < 8; i++) begin
            dmem_resp = (i > 0);
            eval();
            if (hit < 0 && o_ready[0][2]) hit = i;
            commit();
        end
        chk("r036_starve", (hit >= 0 && hit <= 4), 1);
        req_valid = '0; dmem_resp = 1'b1; cyc(); dmem_resp = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            rand_data();
            req_valid     = N'($urandom);
            backend_flush = ($urandom_range(0, 5) == 0);
            dmem_resp     = m_pend[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 249) == 0) do_reset();
            else cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter_n.md
DMEM_ARBITER_N -- requirements
Module: dmem_arbiter_n

Interface
- REQ-001 SHALL have parameter NUM_CH, default 3: number of requester channels, 2..8.
- REQ-002 SHALL have parameter ADDR_W, default 32: address width.
- REQ-003 SHALL have parameter DATA_W, default 32: data width; MASK_W = DATA_W/8.
- REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- REQ-005 SHALL have parameter FLUSH_MASK, default NUM_CH'b1: bit i set = channel i responses are squashed by flush.
- REQ-006 SHALL have parameter STARVE_LIMIT, default 16: starvation threshold in cycles (used only under REQ-027).
- REQ-007 Ports (one clock; reset asynchronous, active-high):
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  backend_flush  in  1  pipeline flush
  req_valid  in  NUM_CH  per-channel request valid
  req_ready  out  NUM_CH  per-channel grant
  req_addr  in  NUM_CH x ADDR_W  per-channel address
  req_rmask  in  NUM_CH x MASK_W  per-channel read mask
  req_wmask  in  NUM_CH x MASK_W  per-channel write mask
  req_wdata  in  NUM_CH x DATA_W  per-channel write data
  resp_valid  out  NUM_CH  per-channel response strobe
  resp_rdata  out  DATA_W  response data, broadcast to all channels
  dmem_addr  out  ADDR_W  cache address
  dmem_rmask  out  MASK_W  cache read mask
  dmem_wmask  out  MASK_W  cache write mask
  dmem_wdata  out  DATA_W  cache write data
  dmem_rdata  in  DATA_W  cache read data
  dmem_resp  in  1  cache response, one cycle per request

Function
- REQ-008 SHALL allow at most one outstanding cache request.
- REQ-009 busy SHALL equal pending && ~dmem_resp; a new grant can issue in the same cycle as dmem_resp.
- REQ-010 req_ready SHALL be one-hot or zero, combinational, and asserted only for a valid channel while ~busy && ~flushed.
- REQ-011 Handshake (req_valid[i] && req_ready[i]) SHALL drive channel i's addr/rmask/wmask/wdata onto dmem_* in that same cycle.
- REQ-012 With no handshake, dmem_rmask and dmem_wmask SHALL be 0; dmem_addr and dmem_wdata are don't-care.
- REQ-013 ARB_MODE 0 SHALL grant the lowest-index valid channel.
- REQ-014 ARB_MODE 1 SHALL grant the first valid channel at or after rr_ptr, wrapping modulo NUM_CH.
- REQ-015 In ARB_MODE 1, rr_ptr SHALL advance to (granted+1) mod NUM_CH on each handshake, and SHALL wrap NUM_CH-1 -> 0.
- REQ-016 A handshake SHALL set pending and latch the granted channel index into owner.
- REQ-017 dmem_resp SHALL clear pending unless a new handshake occurs in the same cycle (handshake wins).
- REQ-018 resp_valid[owner] SHALL be asserted iff dmem_resp && pending && ~flushed; all other bits SHALL be 0.
- REQ-019 resp_rdata SHALL equal dmem_rdata combinationally.
- REQ-020 backend_flush while busy and FLUSH_MASK[owner]=1 SHALL set flushed; dmem_resp SHALL clear flushed.
- REQ-021 While flushed is set, no grant SHALL issue.
- REQ-022 Flush while busy for a non-flushable owner SHALL leave its response delivered.
- REQ-023 Flush while idle SHALL have no effect.
- REQ-024 dmem_resp with pending=0 SHALL be ignored.

Reset
- REQ-025 rst SHALL asynchronously clear pending, flushed and owner to 0, and set rr_ptr to 0 and all starvation counters to 0.
- REQ-026 During and after reset, req_ready, resp_valid, dmem_rmask and dmem_wmask SHALL be 0 until the first grant; a request in flight at reset is abandoned.

Configuration
- REQ-027 With macro DMEM_ARB_STARVE_GUARD_EN defined, each channel SHALL have a saturating wait counter that increments each cycle it is valid but not granted, and clears on its grant.
- REQ-028 With DMEM_ARB_STARVE_GUARD_EN defined, a channel whose counter is >= STARVE_LIMIT SHALL take priority over REQ-013/014; among several such channels, the lowest index wins.
- REQ-029 Without DMEM_ARB_STARVE_GUARD_EN, no counters SHALL exist and arbitration is purely per ARB_MODE.

Structure
- REQ-030 Package dmem_arb_pkg SHALL hold the arb_mode_t enum (ARB_FIXED=0, ARB_RR=1) and the MAX_CH=8 constant.
- REQ-031 Grant selection SHALL live in sub-module dmem_arb_sel (valid vector, rr_ptr, mode, starve vector -> one-hot grant).

Verification
- REQ-032 NUM_CH=3, mode 0, valid=3'b111 for 3 grants each followed by dmem_resp -> grants in order ch0, ch0, ch0; ch1 and ch2 never ready.
- REQ-033 Mode 1, valid=3'b111 continuously -> grant order ch0, ch1, ch2, ch0, with exactly one resp_valid bit per dmem_resp.
- REQ-034 ch0 read granted at addr 0x100; flush in the next cycle; dmem_resp 2 cycles later -> resp_valid=0, no grant issued while flushed, ch1 granted in the dmem_resp cycle.
- REQ-035 FLUSH_MASK=3'b001, ch1 store wmask=4'hF granted, then flush -> resp_valid[1]=1 on dmem_resp.
- REQ-036 DMEM_ARB_STARVE_GUARD_EN, mode 0, STARVE_LIMIT=4, ch0 and ch2 always valid -> ch2 granted no later than its 5th arbitration cycle.
- REQ-037 Assert rst mid-request (pending=1), then dmem_resp after release -> no resp_valid, and req_ready is asserted again in the first cycle after reset.
